// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline hazard/exception controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PCSEL_SEQ = 2'b00,
    PCSEL_BR  = 2'b01,
    PCSEL_EXC = 2'b10,
    PCSEL_EPC = 2'b11
  } pc_sel_e;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_e;

  localparam int unsigned VEC_NONE         = 0;
  localparam logic [31:0] EXC_BASE_DEFAULT = 32'h0000_0080;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: the load in EX writes a register the ID instruction reads.
module hazard_detect (
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       load_use_c
);

  localparam int unsigned REG_W = 5;

  assign load_use_c = ex_memread && (ex_rd != REG_W'(0)) &&
                      ((ex_rd == id_rs) || (ex_rd == id_rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 5-stage core: stall/flush steering, multi-cycle EX
// sequencing and EPC/cause ownership for exception entry and eret.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned       XLEN     = 32,
  parameter int unsigned       VEC_W    = 5,
  parameter logic [XLEN-1:0]   EXC_BASE = XLEN'(EXC_BASE_DEFAULT),
  parameter int unsigned       MC_LAT   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             ex_mc_start,
  input  logic [VEC_W-1:0] mem_vector,
  input  logic [XLEN-1:0]  mem_pc,
  input  logic             mem_eret,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             if_flush,
  output logic             id_flush,
  output logic             ex_flush,
  output logic [1:0]       pc_sel,
  output logic [XLEN-1:0]  exc_target,
  output logic [XLEN-1:0]  epc,
  output logic [VEC_W-1:0] cause,
  output logic             exc_active,
  output logic             exc_overflow
);

  localparam int unsigned     CNT_W    = $clog2(MC_LAT);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_LAT - 2);

  state_e           state;
  logic [CNT_W-1:0] cnt;

  logic vec_hit;
  logic exc_take;
  logic exc_nested;
  logic eret_take;
  logic mc_stall;
  logic load_use_c;

  hazard_detect u_hazard_detect (
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .load_use_c (load_use_c)
  );

  assign vec_hit    = (mem_vector != VEC_W'(VEC_NONE));
  assign exc_take   = vec_hit && !exc_active;
  assign exc_nested = vec_hit && exc_active;
  assign eret_take  = mem_eret && exc_active;
  // Entering cycle stalls as well as every waiting cycle with cnt still nonzero.
  assign mc_stall   = ((state == RUN) && ex_mc_start) ||
                      ((state == MC_WAIT) && (cnt != CNT_W'(0)));

  // Steering decode, highest priority first.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    id_ex_write = 1'b1;
    if_flush    = 1'b0;
    id_flush    = 1'b0;
    ex_flush    = 1'b0;
    pc_sel      = PCSEL_SEQ;
    if (reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      if_flush    = 1'b1;
      id_flush    = 1'b1;
      ex_flush    = 1'b1;
    end else if (exc_take) begin
      if_flush = 1'b1;
      id_flush = 1'b1;
      ex_flush = 1'b1;
      pc_sel   = PCSEL_EXC;
    end else if (eret_take) begin
      if_flush = 1'b1;
      id_flush = 1'b1;
      ex_flush = 1'b1;
      pc_sel   = PCSEL_EPC;
    end else if (mc_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      ex_flush    = 1'b1;
    end else if (ex_branch_taken) begin
      if_flush = 1'b1;
      id_flush = 1'b1;
      pc_sel   = PCSEL_BR;
    end else if (load_use_c) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_flush    = 1'b1;
    end
  end

  assign exc_target = (reset || (pc_sel == PCSEL_EXC)) ? EXC_BASE : epc;

  // Exception registers and multi-cycle sequencer; exception entry aborts MC_WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      cnt          <= CNT_W'(0);
      epc          <= XLEN'(0);
      cause        <= VEC_W'(0);
      exc_active   <= 1'b0;
      exc_overflow <= 1'b0;
    end else begin
      if (exc_nested) begin
        exc_overflow <= 1'b1;
      end
      if (exc_take) begin
        epc        <= mem_pc;
        cause      <= mem_vector;
        exc_active <= 1'b1;
        state      <= RUN;
      end else if (eret_take) begin
        exc_active   <= 1'b0;
        exc_overflow <= 1'b0;
      end else begin
        case (state)
          RUN: begin
            if (ex_mc_start) begin
              cnt   <= CNT_INIT;
              state <= MC_WAIT;
            end
          end
          MC_WAIT: begin
            if (cnt != CNT_W'(0)) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              state <= RUN;
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule
